// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: operand widths, register count,
// special opcodes and the fixed instruction field layout.
package decode_stage_pkg;

  localparam int DATA_W  = 16;
  localparam int NREG    = 8;
  localparam int AW      = 3;
  localparam int INSTR_W = 16;
  localparam int COP_W   = 4;
  localparam int IMM_W   = 9;

  // Opcode whose B operand is the 9-bit immediate (A source is rd)
  localparam logic [COP_W-1:0] IMM_COP = 4'b0011;
  // Opcode treated as a bubble: never writes a register
  localparam logic [COP_W-1:0] NOP_COP = 4'b1111;

  // Instruction field positions (LSB of each field)
  localparam int COP_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RA_LSB  = 6;
  localparam int RB_LSB  = 3;
  localparam int IMM_LSB = 0;

  function automatic logic [COP_W-1:0] f_cop(input logic [INSTR_W-1:0] instr);
    return instr[COP_LSB +: COP_W];
  endfunction

  function automatic logic [AW-1:0] f_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_LSB +: AW];
  endfunction

  function automatic logic [AW-1:0] f_ra(input logic [INSTR_W-1:0] instr);
    return instr[RA_LSB +: AW];
  endfunction

  function automatic logic [AW-1:0] f_rb(input logic [INSTR_W-1:0] instr);
    return instr[RB_LSB +: AW];
  endfunction

  function automatic logic [IMM_W-1:0] f_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_LSB +: IMM_W];
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 8x16 architectural register file: one write port, two combinational read
// ports, asynchronous clear of every entry.
module decode_stage_reg_file
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  // All entries flattened into one bus so each entry can live in its own
  // generate scope without sharing an array between processes.
  logic [NREG*DATA_W-1:0] entries;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_q;
      logic [DATA_W-1:0] entry_d;

      // Next value: take the writeback data when this entry is addressed
      always_comb begin
        entry_d = entry_q;
        if (we && (waddr == AW'(gi))) begin
          entry_d = wdata;
        end
      end

      // Entry storage, cleared asynchronously
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign entries[gi*DATA_W +: DATA_W] = entry_q;
    end
  endgenerate

  assign rdata_a = entries[int'(raddr_a)*DATA_W +: DATA_W];
  assign rdata_b = entries[int'(raddr_b)*DATA_W +: DATA_W];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: latches one instruction per enabled cycle, decodes it, reads
// the register file and forwards from the ALU stage and the writeback port.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_decode,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  input  logic              wb_we,
  input  logic [2:0]        wb_addr,
  input  logic [15:0]       wb_data,
  input  logic              alu_we,
  input  logic [2:0]        alu_dest,
  input  logic [15:0]       alu_result,
  output logic [15:0]       regA,
  output logic [15:0]       regB,
  output logic [3:0]        cop,
  output logic [2:0]        destReg_addr,
  output logic              we,
  output logic [8:0]        inmediate
);

  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] ir_d;
  logic               valid_q;
  logic               valid_d;

  logic [AW-1:0]      src_a;
  logic [AW-1:0]      src_b;
  logic [DATA_W-1:0]  rf_a;
  logic [DATA_W-1:0]  rf_b;

  // Operand source priority: ALU stage result, then same-cycle writeback,
  // then the stored register value. r0 is an ordinary register here.
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [AW-1:0]     src,
    input logic              f_alu_we,
    input logic [AW-1:0]     f_alu_dest,
    input logic [DATA_W-1:0] f_alu_result,
    input logic              f_wb_we,
    input logic [AW-1:0]     f_wb_addr,
    input logic [DATA_W-1:0] f_wb_data,
    input logic [DATA_W-1:0] f_rf
  );
    if (f_alu_we && (f_alu_dest == src)) begin
      return f_alu_result;
    end else if (f_wb_we && (f_wb_addr == src)) begin
      return f_wb_data;
    end else begin
      return f_rf;
    end
  endfunction

  // Instruction register next state: load when the stage is enabled
  always_comb begin
    ir_d    = ir_q;
    valid_d = valid_q;
    if (enable_decode) begin
      ir_d    = instruction;
      valid_d = instr_valid;
    end
  end

  // Instruction register; reset leaves a NOP encoding with valid cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q    <= {NOP_COP, {(INSTR_W-COP_W){1'b0}}};
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  // Field decode; an invalid slot is presented to the ALU as a NOP
  always_comb begin
    cop          = valid_q ? f_cop(ir_q) : NOP_COP;
    destReg_addr = f_rd(ir_q);
    inmediate    = f_imm(ir_q);
    we           = valid_q && (cop != NOP_COP);
    // The immediate form operates in place on rd, so A comes from rd
    src_a        = (cop == IMM_COP) ? f_rd(ir_q) : f_ra(ir_q);
    src_b        = f_rb(ir_q);
  end

  decode_stage_reg_file u_reg_file (
    .clk     (clk),
    .rst     (reset),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (src_a),
    .raddr_b (src_b),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // Operand bypass; B is produced for the immediate form too and the ALU
  // stage simply ignores it
  always_comb begin
    regA = pick_operand(src_a, alu_we, alu_dest, alu_result,
                        wb_we, wb_addr, wb_data, rf_a);
    regB = pick_operand(src_b, alu_we, alu_dest, alu_result,
                        wb_we, wb_addr, wb_data, rf_b);
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by a
// randomized run, all compared against a register-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_decode;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        alu_we;
  logic [2:0]  alu_dest;
  logic [15:0] alu_result;
  logic [15:0] regA;
  logic [15:0] regB;
  logic [3:0]  cop;
  logic [2:0]  destReg_addr;
  logic        we;
  logic [8:0]  inmediate;

  // Reference model state
  logic [15:0] m_rf [8];
  logic [15:0] m_ir;
  logic        m_valid;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .enable_decode (enable_decode),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .alu_we        (alu_we),
    .alu_dest      (alu_dest),
    .alu_result    (alu_result),
    .regA          (regA),
    .regB          (regB),
    .cop           (cop),
    .destReg_addr  (destReg_addr),
    .we            (we),
    .inmediate     (inmediate)
  );

  function automatic logic [15:0] mk(input logic [3:0] c, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {c, rd, ra, rb, 3'b000};
  endfunction

  // Value an operand should carry given the current forwarding inputs
  function automatic logic [15:0] m_operand(input logic [2:0] src);
    if (alu_we && alu_dest == src) return alu_result;
    if (wb_we && wb_addr == src)   return wb_data;
    return m_rf[src];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_ir    = 16'hF000;
    m_valid = 1'b0;
  endtask

  task automatic cmp(input string tag, input string name,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, exp);
    end
  endtask

  // Compare every output against the model for the present inputs
  task automatic check(input string tag);
    logic [3:0]  e_cop;
    logic        e_we;
    logic [2:0]  sa;
    e_cop = m_valid ? m_ir[15:12] : 4'hF;
    e_we  = m_valid && (e_cop != 4'hF);
    sa    = (e_cop == 4'h3) ? m_ir[11:9] : m_ir[8:6];
    txn++;
    $display("txn %0d %s cop=%h we=%b rd=%0d imm=%h A=%h B=%h",
             txn, tag, cop, we, destReg_addr, inmediate, regA, regB);
    cmp(tag, "cop",  {12'b0, cop},          {12'b0, e_cop});
    cmp(tag, "we",   {15'b0, we},           {15'b0, e_we});
    cmp(tag, "dest", {13'b0, destReg_addr}, {13'b0, m_ir[11:9]});
    cmp(tag, "imm",  {7'b0, inmediate},     {7'b0, m_ir[8:0]});
    cmp(tag, "regA", regA,                  m_operand(sa));
    cmp(tag, "regB", regB,                  m_operand(m_ir[5:3]));
  endtask

  // Advance one clock, updating the model with what the edge captures
  task automatic tick();
    @(posedge clk);
    if (wb_we) m_rf[wb_addr] = wb_data;
    if (enable_decode) begin
      m_ir    = instruction;
      m_valid = instr_valid;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable_decode = 1'b0; instruction = 16'h0000; instr_valid = 1'b0;
    wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
    alu_we = 1'b0; alu_dest = 3'd0; alu_result = 16'h0000;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #2 check("reset_state");
    cmp("reset_state", "cop_const", {12'b0, cop}, 16'h000F);

    // Writeback r3, then decode an ADD reading r3 twice
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
    tick();
    wb_we = 1'b0; enable_decode = 1'b1; instr_valid = 1'b1;
    instruction = mk(4'h0, 3'd1, 3'd3, 3'd3);
    tick();
    #2 check("rf_read");
    cmp("rf_read", "regA_const", regA, 16'h1234);
    cmp("rf_read", "regB_const", regB, 16'h1234);

    // Same-cycle writeback bypass on A, then the stored value
    instruction = mk(4'h1, 3'd2, 3'd5, 3'd0);
    tick();
    enable_decode = 1'b0;
    wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'hBEEF;
    #2 check("wb_bypass");
    cmp("wb_bypass", "regA_const", regA, 16'hBEEF);
    tick();
    wb_we = 1'b0;
    #2 check("wb_stored");

    // ALU forward beats writeback to the same register
    enable_decode = 1'b1;
    instruction = mk(4'h2, 3'd6, 3'd0, 3'd2);
    tick();
    enable_decode = 1'b0;
    alu_we = 1'b1; alu_dest = 3'd2; alu_result = 16'h00FF;
    wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'h1111;
    #2 check("alu_priority");
    cmp("alu_priority", "regB_const", regB, 16'h00FF);
    tick();
    alu_we = 1'b0; wb_we = 1'b0;
    #2 check("rf_took_wb");

    // Immediate form: A from rd, immediate field exposed
    wb_we = 1'b1; wb_addr = 3'd4; wb_data = 16'h0007;
    tick();
    wb_we = 1'b0; enable_decode = 1'b1;
    instruction = {4'h3, 3'd4, 9'h1A5};
    tick();
    #2 check("imm_form");
    cmp("imm_form", "regA_const", regA, 16'h0007);
    cmp("imm_form", "imm_const", {7'b0, inmediate}, 16'h01A5);

    // Bubble insertion, then hold with a changing instruction
    instr_valid = 1'b0; instruction = mk(4'h5, 3'd1, 3'd1, 3'd1);
    tick();
    #2 check("bubble");
    enable_decode = 1'b0; instr_valid = 1'b1; instruction = mk(4'h6, 3'd7, 3'd2, 3'd4);
    tick();
    #2 check("hold");

    // Randomized run
    for (int n = 0; n < 300; n++) begin
      logic [3:0] rc;
      case ($urandom_range(0, 3))
        0:       rc = 4'hF;
        1:       rc = 4'h3;
        default: rc = 4'($urandom_range(0, 15));
      endcase
      enable_decode = ($urandom_range(0, 4) != 0);
      instr_valid   = ($urandom_range(0, 4) != 0);
      instruction   = {rc, 12'($urandom)};
      wb_we         = 1'($urandom);
      wb_addr       = 3'($urandom);
      wb_data       = 16'($urandom);
      alu_we        = 1'($urandom);
      alu_dest      = 3'($urandom);
      alu_result    = 16'($urandom);
      #2 check("rand");
      tick();
    end

    // Reset asserted mid-cycle with a loaded IR and populated regfile
    alu_we = 1'b0; wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'hA5A5;
    enable_decode = 1'b1; instr_valid = 1'b1; instruction = mk(4'h4, 3'd5, 3'd3, 3'd3);
    tick();
    wb_we = 1'b0; enable_decode = 1'b0;
    #2 check("pre_reset");
    reset = 1'b1;
    #1 model_reset();
    check("mid_reset");
    cmp("mid_reset", "regA_const", regA, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #2 check("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
